// File: rtl/divider_param.sv
// Sequential radix-2 restoring unsigned divider: one quotient bit per clock,
// explicit divide-by-zero result, Start/Ack handshake safe for a shared pulse.
module divider_param #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] Xin,
  input  logic [W-1:0] Yin,
  input  logic         Start,
  input  logic         Ack,
  output logic [W-1:0] Quotient,
  output logic [W-1:0] Remainder,
  output logic         Done,
  output logic         DivByZero,
  output logic         Qi,
  output logic         Qc,
  output logic         Qd
);

  // One-hot encoding so the state indicators come straight off the register.
  typedef enum logic [2:0] {
    ST_INIT = 3'b100,
    ST_COMP = 3'b010,
    ST_DONE = 3'b001
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbz_q, dbz_d;
  logic [W:0]      t_c;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      x_q     <= '0;
      y_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath; the partial remainder needs one extra bit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    t_c     = {rem_q, x_q[cnt_q]};

    unique case (state_q)
      ST_INIT: begin
        if (Start) begin
          x_d   = Xin;
          y_d   = Yin;
          cnt_d = CW'(W - 1);
          dbz_d = (Yin == '0);
          if (Yin == '0) begin
            quo_d   = '1;
            rem_d   = Xin;
            state_d = ST_DONE;
          end else begin
            quo_d   = '0;
            rem_d   = '0;
            state_d = ST_COMP;
          end
        end
      end
      ST_COMP: begin
        if (t_c >= {1'b0, y_q}) begin
          rem_d        = W'(t_c - {1'b0, y_q});
          quo_d[cnt_q] = 1'b1;
        end else begin
          rem_d = t_c[W-1:0];
        end
        cnt_d = CW'(cnt_q - 1'b1);
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Ack) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Qi        = state_q[2];
  assign Qc        = state_q[1];
  assign Qd        = state_q[0];
  assign Done      = state_q[0];

endmodule
